// File: rtl/fb_reader_pkg.sv
// -----------------------------------------------------------------------------
// fb_reader_pkg
// Shared definitions for the frame-buffer read client and its FIFO:
//   MEM_AW / MEM_DW : word-address and data widths of the DDR controller port
//   MEMLEN_4        : burst length field for a 4-word burst (length minus one)
//   BURST_WORDS     : number of words moved by one burst
//   fb_state_t      : fb_reader FSM state encoding
//   nextBurstAddr   : advance a burst address by one burst, wrapping at 2^MEM_AW
// -----------------------------------------------------------------------------
package fb_reader_pkg;

    localparam int         MEM_AW      = 23;
    localparam int         MEM_DW      = 32;
    localparam logic [1:0] MEMLEN_4    = 2'd3;
    localparam int         BURST_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_REQ   = 2'd2,
        ST_DRAIN = 2'd3
    } fb_state_t;

    // Address arithmetic deliberately drops the carry so a frame placed at the
    // top of memory continues at word 0.
    function automatic logic [MEM_AW-1:0] nextBurstAddr(input logic [MEM_AW-1:0] addr);
        return addr + MEM_AW'(BURST_WORDS);
    endfunction

endpackage

// File: rtl/fb_reader_fifo.sv
// -----------------------------------------------------------------------------
// fb_reader_fifo
// Synchronous show-ahead FIFO used to buffer frame words between the memory
// port and the downstream scaler. The head word is visible on o_rdata whenever
// o_empty is low; a pop simply advances to the next word.
// Ports:
//   i_clk    in   clock
//   i_rst    in   synchronous active-high reset, flushes the FIFO
//   i_push   in   write i_wdata this cycle
//   i_wdata  in   WIDTH-bit write data
//   i_pop    in   discard the head word this cycle
//   o_rdata  out  head word (show-ahead)
//   o_full   out  DEPTH words stored
//   o_empty  out  no words stored
//   o_count  out  number of stored words, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fb_reader_fifo
    import fb_reader_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = MEM_DW
)(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;

    logic             w_doPush;
    logic             w_doPop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_count  = r_count;
    assign o_rdata  = r_mem[r_rdPtr];

    // A pop on an empty FIFO is ignored. A push into a full FIFO is only
    // allowed when the same cycle pops, because the slot being freed is the
    // one being written.
    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);

    // Storage array: written on push, never reset since the pointers and count
    // define which entries are meaningful.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping. Push and pop together leave the count
    // unchanged while both pointers advance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fb_reader.sv
// -----------------------------------------------------------------------------
// fb_reader
// Frame-buffer read client for one port of the DDR controller. A start pulse
// fetches HRES*VRES words beginning at BASE as 4-word read bursts, buffers them
// in a FIFO and streams them to the scaler over a valid/ready handshake.
// Ports:
//   i_clk        in   system clock, shared with the memory controller
//   i_rst        in   synchronous active-high reset
//   i_start      in   one-cycle pulse, begin fetching a frame (ignored while busy)
//   o_busy       out  high from start until the frame has fully left the FIFO
//   o_memaddr    out  burst start word address (registered)
//   o_memlen     out  burst length minus one, always 4-word bursts
//   o_memwr      out  always 0, this client only reads
//   o_memreq     out  burst request, held until the 4th ack
//   i_memack     in   one pulse per transferred word
//   i_memrdata   in   read word, valid with i_memack
//   o_pixdata    out  FIFO head word
//   o_pixvalid   out  o_pixdata is valid
//   i_pixready   in   downstream accepts o_pixdata when valid and ready
// -----------------------------------------------------------------------------
module fb_reader
    import fb_reader_pkg::*;
#(
    parameter logic [MEM_AW-1:0] BASE  = 23'h000000,
    parameter int                HRES  = 160,
    parameter int                VRES  = 240,
    parameter int                DEPTH = 16
)(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    output logic                o_busy,
    output logic [MEM_AW-1:0]   o_memaddr,
    output logic [1:0]          o_memlen,
    output logic                o_memwr,
    output logic                o_memreq,
    input  logic                i_memack,
    input  logic [MEM_DW-1:0]   i_memrdata,
    output logic [MEM_DW-1:0]   o_pixdata,
    output logic                o_pixvalid,
    input  logic                i_pixready
);

    localparam int TOTAL = HRES * VRES;
    localparam int WCW   = $clog2(TOTAL + 1);
    localparam int CW    = $clog2(DEPTH) + 1;

    localparam logic [WCW-1:0] TOTAL_W = WCW'(TOTAL);

    fb_state_t        r_state;
    logic             r_memreq;
    logic [MEM_AW-1:0] r_memaddr;
    logic [1:0]       r_memlen;
    logic             r_busy;
    logic [1:0]       r_ackCnt;
    logic [WCW-1:0]   r_wordsIssued;
    logic [2:0]       r_outstanding;

    logic             w_ackAccept;
    logic             w_pop;
    logic             w_fifoFull;
    logic             w_fifoEmpty;
    logic [CW-1:0]    w_fifoCount;
    logic [MEM_DW-1:0] w_fifoRdata;
    logic [CW:0]      w_used;
    logic             w_spaceOk;

    // Acks are only taken while a burst is actually requested. After a reset
    // the controller may still deliver the rest of an aborted burst; memreq is
    // low then, so those words never reach the FIFO.
    assign w_ackAccept = i_memack & r_memreq & (r_state == ST_REQ);

    assign w_pop = ~w_fifoEmpty & i_pixready;

    // Credit check: words already buffered plus words still owed by the
    // controller must leave room for a whole burst, so an ack can never find
    // the FIFO full.
    assign w_used    = (CW+1)'(w_fifoCount) + (CW+1)'(r_outstanding);
    assign w_spaceOk = ~w_fifoFull &
                       ((w_used + (CW+1)'(BURST_WORDS)) <= (CW+1)'(DEPTH));

    fb_reader_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (MEM_DW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_ackAccept),
        .i_wdata (i_memrdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifoRdata),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty),
        .o_count (w_fifoCount)
    );

    // Main fetch FSM. IDLE waits for start, FETCH decides whether another
    // burst can be issued, REQ holds the request until four words have
    // arrived, DRAIN waits for the last buffered word to leave. All port
    // outputs are registered here, and the cycle spent in FETCH after each
    // burst provides the idle gap the controller expects between requests.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_memreq      <= 1'b0;
            r_memaddr     <= BASE;
            r_memlen      <= MEMLEN_4;
            r_busy        <= 1'b0;
            r_ackCnt      <= 2'd0;
            r_wordsIssued <= '0;
            r_outstanding <= 3'd0;
        end else begin
            r_memlen <= MEMLEN_4;
            if (w_ackAccept) begin
                r_outstanding <= r_outstanding - 3'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state       <= ST_FETCH;
                        r_memaddr     <= BASE;
                        r_wordsIssued <= '0;
                        r_ackCnt      <= 2'd0;
                        r_busy        <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (r_wordsIssued == TOTAL_W) begin
                        r_state <= ST_DRAIN;
                    end else if (w_spaceOk) begin
                        r_state       <= ST_REQ;
                        r_memreq      <= 1'b1;
                        r_ackCnt      <= 2'd0;
                        r_outstanding <= 3'(BURST_WORDS);
                    end
                end
                ST_REQ: begin
                    if (w_ackAccept) begin
                        r_ackCnt <= r_ackCnt + 2'd1;
                        if (r_ackCnt == 2'd3) begin
                            r_memreq      <= 1'b0;
                            r_memaddr     <= nextBurstAddr(r_memaddr);
                            r_wordsIssued <= r_wordsIssued + WCW'(BURST_WORDS);
                            r_state       <= ST_FETCH;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_fifoEmpty && (r_outstanding == 3'd0)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_memaddr  = r_memaddr;
    assign o_memlen   = r_memlen;
    assign o_memwr    = 1'b0;
    assign o_memreq   = r_memreq;
    assign o_pixdata  = w_fifoRdata;
    assign o_pixvalid = ~w_fifoEmpty;

endmodule

// File: tb/tb_fb_reader.sv
// -----------------------------------------------------------------------------
// tb_fb_reader
// Self-checking bench for fb_reader. A behavioural memory answers each burst
// with four acks separated by random gaps; expected burst addresses and frame
// words are queued when a frame is started, and independent processes compare
// the DUT's bursts and output words against those queues.
// -----------------------------------------------------------------------------
module tb_fb_reader;

    localparam logic [22:0] BASE_P  = 23'h7FFFF8;
    localparam int          HRES_P  = 8;
    localparam int          VRES_P  = 4;
    localparam int          DEPTH_P = 16;
    localparam int          TOTAL   = HRES_P * VRES_P;
    localparam int          BURSTS  = TOTAL / 4;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        start    = 1'b0;
    logic        memack   = 1'b0;
    logic [31:0] memrdata = 32'h0;
    logic        pixready = 1'b0;

    logic        busy;
    logic [22:0] memaddr;
    logic [1:0]  memlen;
    logic        memwr;
    logic        memreq;
    logic [31:0] pixdata;
    logic        pixvalid;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] memSeed = 32'h0;
    logic [31:0] expQ[$];
    logic [22:0] addrQ[$];
    int          popCount       = 0;
    int          burstCount     = 0;
    int          wordsDelivered = 0;
    int          maxOcc         = 0;
    int          ackInBurst     = 0;
    int          readyMode      = 0;
    bit          abortBurst     = 1'b0;

    fb_reader #(
        .BASE  (BASE_P),
        .HRES  (HRES_P),
        .VRES  (VRES_P),
        .DEPTH (DEPTH_P)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .o_busy     (busy),
        .o_memaddr  (memaddr),
        .o_memlen   (memlen),
        .o_memwr    (memwr),
        .o_memreq   (memreq),
        .i_memack   (memack),
        .i_memrdata (memrdata),
        .o_pixdata  (pixdata),
        .o_pixvalid (pixvalid),
        .i_pixready (pixready)
    );

    always #5 clk = ~clk;

    // Contents of the modelled frame buffer: a scrambled function of the word
    // address, re-seeded for every frame.
    function automatic logic [31:0] memWord(input logic [22:0] a);
        return {a[8:0], a} ^ memSeed;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Downstream ready: always on, stalled, or a random 50% pattern. Changed
    // just after the rising edge so it is stable when sampled.
    initial begin : readyDriver
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       pixready = 1'b1;
                1:       pixready = 1'b0;
                default: pixready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Behavioural memory controller: on each new request check the burst
    // against the expected address list, then deliver four words with random
    // 0-5 cycle gaps while checking the request stays stable.
    initial begin : memModel
        logic [22:0] bAddr;
        int          gap;
        forever begin
            @(negedge clk);
            memack   = 1'b0;
            memrdata = $urandom;
            if (memreq && !rst) begin
                bAddr = memaddr;
                burstCount++;
                ackInBurst = 0;
                if (addrQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL burst address: got %06h, expected no further burst", bAddr);
                end else begin
                    checkOutput("burst address", bAddr, addrQ.pop_front());
                end
                checkOutput("memlen", memlen, 3);
                checkOutput("memwr", memwr, 0);
                for (int k = 0; k < 4; k++) begin
                    gap = $urandom_range(0, 5);
                    repeat (gap) begin
                        memack   = 1'b0;
                        memrdata = $urandom;
                        @(negedge clk);
                        if (!abortBurst && !rst) begin
                            checkOutput("memreq held", memreq, 1);
                            checkOutput("memaddr held", memaddr, bAddr);
                        end
                    end
                    memack     = 1'b1;
                    memrdata   = memWord(bAddr + 23'(k));
                    ackInBurst = k + 1;
                    if (!abortBurst) wordsDelivered++;
                    @(negedge clk);
                    if (k < 3 && !abortBurst && !rst) begin
                        checkOutput("memreq held", memreq, 1);
                        checkOutput("memaddr held", memaddr, bAddr);
                    end
                end
                memack   = 1'b0;
                memrdata = $urandom;
                if (!abortBurst && !rst) checkOutput("memreq drop", memreq, 0);
            end
        end
    end

    // Output monitor: every accepted word is compared with the next expected
    // frame word, and peak buffering is tracked.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst && (wordsDelivered - popCount) > maxOcc) maxOcc = wordsDelivered - popCount;
            if (pixvalid && pixready && !rst) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL pixdata: got extra word %0h, expected none", pixdata);
                end else begin
                    checkOutput("pixdata", pixdata, expQ.pop_front());
                end
                popCount++;
            end
        end
    end

    task automatic loadFrame();
        logic [22:0] a;
        memSeed = $urandom;
        expQ.delete();
        addrQ.delete();
        for (int n = 0; n < TOTAL; n++) begin
            a = BASE_P + 23'(n);
            expQ.push_back(memWord(a));
        end
        for (int b = 0; b < BURSTS; b++) begin
            a = BASE_P + 23'(4 * b);
            addrQ.push_back(a);
        end
        maxOcc = 0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " memreq"}, memreq, 0);
        checkOutput({tag, " memaddr"}, memaddr, BASE_P);
        checkOutput({tag, " memlen"}, memlen, 3);
        checkOutput({tag, " memwr"}, memwr, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " pixvalid"}, pixvalid, 0);
    endtask

    // One full frame. mode selects the ready pattern, stall holds ready low
    // first to exercise the credit limit, pulseStart fires extra start pulses
    // while the frame is in progress.
    task automatic applyStimulus(input int mode, input bit stall, input bit pulseStart);
        int popBase;
        int burstBase;
        int cyc;
        loadFrame();
        popBase   = popCount;
        burstBase = burstCount;
        readyMode = stall ? 1 : mode;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy after start", busy, 1);
        if (stall) begin
            repeat (200) @(negedge clk);
            checkOutput("stall bursts", burstCount - burstBase, 4);
            checkOutput("stall memreq", memreq, 0);
            checkOutput("stall pixvalid", pixvalid, 1);
            checkOutput("stall buffered", wordsDelivered - popCount, DEPTH_P);
            readyMode = mode;
        end
        cyc = 0;
        while ((popCount - popBase) < TOTAL && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start = (pulseStart && (cyc == 37 || cyc == 90)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        checkOutput("frame words", popCount - popBase, TOTAL);
        cyc = 0;
        while (busy && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("busy falls", busy, 0);
        repeat (20) @(negedge clk);
        checkOutput("no extra words", popCount - popBase, TOTAL);
        checkOutput("burst count", burstCount - burstBase, BURSTS);
        checkOutput("words pending", expQ.size(), 0);
        checkOutput("bursts pending", addrQ.size(), 0);
        checkOutput("occupancy within depth", (maxOcc <= DEPTH_P), 1);
    endtask

    // Reset in the middle of a burst: state must clear at once and the rest of
    // the aborted burst must not land in the FIFO.
    task automatic resetMidBurst();
        int burstBase;
        int cyc;
        bit sawActivity;
        loadFrame();
        burstBase = burstCount;
        readyMode = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!((burstCount - burstBase) >= 2 && ackInBurst == 2) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("reach 2nd ack", (cyc < 2000), 1);
        abortBurst = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        checkResetState("mid-burst reset");
        rst = 1'b0;
        expQ.delete();
        addrQ.delete();
        wordsDelivered = popCount;
        sawActivity = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (pixvalid || memreq || busy) sawActivity = 1'b1;
        end
        checkOutput("stray acks discarded", sawActivity, 0);
        abortBurst = 1'b0;
        wordsDelivered = popCount;
    endtask

    initial begin : main
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] frame with ready always high");
        applyStimulus(0, 1'b0, 1'b0);
        $display("[TB] frame with initial downstream stall");
        applyStimulus(0, 1'b1, 1'b0);
        $display("[TB] frame with random ready and start pulses while busy");
        applyStimulus(2, 1'b0, 1'b1);
        $display("[TB] reset in the middle of a burst");
        resetMidBurst();
        $display("[TB] refetch after reset with random ready");
        applyStimulus(2, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
